// File: rtl/lfst_multi.sv
// Last-fetched-store table for store-set memory dependence prediction.
// Holds, per store-set ID, the tag of the most recently renamed store.
// W lookups per cycle with forwarding from older slots of the same bundle,
// W updates and INV_P retire-invalidates per cycle, flush and periodic sweep.
module lfst_multi #(
    parameter int NUM_SSID   = 128,
    parameter int SSID_W     = 7,
    parameter int TAG_W      = 7,
    parameter int W          = 4,
    parameter int INV_P      = 2,
    parameter int CLR_PERIOD = 0,
    parameter int OCC_W      = 8
) (
    input  logic                   clock,
    input  logic                   reset_n,
    input  logic                   flush_in,
    input  logic [W*SSID_W-1:0]    lk_ssid_in,
    input  logic [W-1:0]           lk_vld_in,
    input  logic [W*SSID_W-1:0]    upd_ssid_in,
    input  logic [W*TAG_W-1:0]     upd_tag_in,
    input  logic [W-1:0]           upd_vld_in,
    input  logic [INV_P*TAG_W-1:0] inv_tag_in,
    input  logic [INV_P-1:0]       inv_vld_in,
    output logic [W*TAG_W-1:0]     lfs_out,
    output logic [W-1:0]           lfs_vld_out,
    output logic [OCC_W-1:0]       occ_out,
    output logic                   clr_pulse_out
);

    // Sweep counter needs to reach CLR_PERIOD-1; keep at least one bit so the
    // disabled configuration still elaborates.
    localparam int CNT_W = (CLR_PERIOD > 1) ? $clog2(CLR_PERIOD) : 1;
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'((CLR_PERIOD > 0) ? CLR_PERIOD - 1 : 0);

    logic [TAG_W-1:0]    r_tag [NUM_SSID];
    logic [NUM_SSID-1:0] r_vld;
    logic [CNT_W-1:0]    r_cnt;
    logic                r_clr_pulse;

    logic [TAG_W-1:0]    w_tag_d [NUM_SSID];
    logic [NUM_SSID-1:0] w_vld_d;
    logic [CNT_W-1:0]    w_cnt_d;
    logic                w_clr_fire;
    logic                w_lk_en;
    logic [TAG_W-1:0]    w_lk_tag [W];
    logic [W-1:0]        w_lk_hit;
    logic [OCC_W-1:0]    w_occ;

    // Flush outranks the sweep, so a flush on the terminal count swallows it.
    assign w_clr_fire = (CLR_PERIOD > 0) && !flush_in && (r_cnt == CNT_MAX);

    // Lookups are blanked while reset is held so outputs drop asynchronously.
    assign w_lk_en = !flush_in && !reset_n;

    // Per-slot table read, overridden by the youngest older-slot update.
    always_comb begin
        for (int k = 0; k < W; k++) begin
            w_lk_tag[k] = r_tag[lk_ssid_in[k*SSID_W +: SSID_W]];
            w_lk_hit[k] = r_vld[lk_ssid_in[k*SSID_W +: SSID_W]];
            // Ascending scan: the highest matching older slot is written last.
            for (int j = 0; j < W; j++) begin
                if (j < k && upd_vld_in[j] &&
                    upd_ssid_in[j*SSID_W +: SSID_W] == lk_ssid_in[k*SSID_W +: SSID_W]) begin
                    w_lk_tag[k] = upd_tag_in[j*TAG_W +: TAG_W];
                    w_lk_hit[k] = 1'b1;
                end
            end
        end
    end

    // Qualify lookup results; tag reads as zero whenever the slot is invalid.
    always_comb begin
        lfs_out     = '0;
        lfs_vld_out = '0;
        for (int k = 0; k < W; k++) begin
            lfs_vld_out[k] = w_lk_hit[k] & lk_vld_in[k] & w_lk_en;
            if (lfs_vld_out[k]) begin
                lfs_out[k*TAG_W +: TAG_W] = w_lk_tag[k];
            end
        end
    end

    // Next table state: clear-all, else invalidates then updates (update wins).
    always_comb begin
        w_vld_d = r_vld;
        w_tag_d = r_tag;
        if (flush_in || w_clr_fire) begin
            w_vld_d = '0;
        end else begin
            for (int e = 0; e < NUM_SSID; e++) begin
                for (int i = 0; i < INV_P; i++) begin
                    if (inv_vld_in[i] && r_tag[e] == inv_tag_in[i*TAG_W +: TAG_W]) begin
                        w_vld_d[e] = 1'b0;
                    end
                end
            end
            // Ascending slot order lets the highest slot win a shared SSID.
            for (int j = 0; j < W; j++) begin
                if (upd_vld_in[j]) begin
                    w_tag_d[upd_ssid_in[j*SSID_W +: SSID_W]] = upd_tag_in[j*TAG_W +: TAG_W];
                    w_vld_d[upd_ssid_in[j*SSID_W +: SSID_W]] = 1'b1;
                end
            end
        end
    end

    // Sweep counter: restarts on flush or after firing, parked when disabled.
    always_comb begin
        w_cnt_d = r_cnt + 1'b1;
        if (flush_in || CLR_PERIOD == 0 || w_clr_fire) begin
            w_cnt_d = '0;
        end
    end

    // State registers with asynchronous reset (reset_n high means reset).
    always_ff @(posedge clock or posedge reset_n) begin
        if (reset_n) begin
            r_vld       <= '0;
            r_cnt       <= '0;
            r_clr_pulse <= 1'b0;
            for (int e = 0; e < NUM_SSID; e++) begin
                r_tag[e] <= '0;
            end
        end else begin
            r_vld       <= w_vld_d;
            r_cnt       <= w_cnt_d;
            r_clr_pulse <= w_clr_fire;
            for (int e = 0; e < NUM_SSID; e++) begin
                r_tag[e] <= w_tag_d[e];
            end
        end
    end

    // Occupancy is a population count of the registered valid bits.
    always_comb begin
        w_occ = '0;
        for (int e = 0; e < NUM_SSID; e++) begin
            w_occ = w_occ + OCC_W'(r_vld[e]);
        end
    end

    assign occ_out       = w_occ;
    assign clr_pulse_out = r_clr_pulse;

endmodule

// File: tb/tb_lfst_multi.sv
// Self-checking bench for lfst_multi: directed scenarios plus random traffic
// against a table model. Two instances share inputs: sweep disabled and
// sweep every 16 cycles.
module tb_lfst_multi;

    localparam int NUM_SSID = 128;
    localparam int SSID_W   = 7;
    localparam int TAG_W    = 7;
    localparam int W        = 4;
    localparam int INV_P    = 2;
    localparam int OCC_W    = 8;
    localparam int PERIOD1  = 16;

    logic clock = 1'b0;
    always #5 clock = ~clock;

    logic                   reset_n = 1'b1;
    logic                   flush_in;
    logic [W*SSID_W-1:0]    lk_ssid_in;
    logic [W-1:0]           lk_vld_in;
    logic [W*SSID_W-1:0]    upd_ssid_in;
    logic [W*TAG_W-1:0]     upd_tag_in;
    logic [W-1:0]           upd_vld_in;
    logic [INV_P*TAG_W-1:0] inv_tag_in;
    logic [INV_P-1:0]       inv_vld_in;

    logic [W*TAG_W-1:0] lfs0, lfs1;
    logic [W-1:0]       lfs_vld0, lfs_vld1;
    logic [OCC_W-1:0]   occ0, occ1;
    logic               clr0, clr1;

    int checks = 0;
    int errors = 0;

    lfst_multi #(.CLR_PERIOD(0)) u_dut0 (
        .clock(clock), .reset_n(reset_n), .flush_in(flush_in),
        .lk_ssid_in(lk_ssid_in), .lk_vld_in(lk_vld_in),
        .upd_ssid_in(upd_ssid_in), .upd_tag_in(upd_tag_in), .upd_vld_in(upd_vld_in),
        .inv_tag_in(inv_tag_in), .inv_vld_in(inv_vld_in),
        .lfs_out(lfs0), .lfs_vld_out(lfs_vld0), .occ_out(occ0), .clr_pulse_out(clr0)
    );

    lfst_multi #(.CLR_PERIOD(PERIOD1)) u_dut1 (
        .clock(clock), .reset_n(reset_n), .flush_in(flush_in),
        .lk_ssid_in(lk_ssid_in), .lk_vld_in(lk_vld_in),
        .upd_ssid_in(upd_ssid_in), .upd_tag_in(upd_tag_in), .upd_vld_in(upd_vld_in),
        .inv_tag_in(inv_tag_in), .inv_vld_in(inv_vld_in),
        .lfs_out(lfs1), .lfs_vld_out(lfs_vld1), .occ_out(occ1), .clr_pulse_out(clr1)
    );

    // Reference model: table contents for each instance plus sweep position.
    bit [TAG_W-1:0] m_tag  [NUM_SSID];
    bit             m_vld  [NUM_SSID];
    bit [TAG_W-1:0] m1_tag [NUM_SSID];
    bit             m1_vld [NUM_SSID];
    int             m1_cnt;
    bit             m1_pulse;

    function automatic int lk_ssid(input int k);
        return int'(lk_ssid_in[k*SSID_W +: SSID_W]);
    endfunction

    function automatic int upd_ssid(input int j);
        return int'(upd_ssid_in[j*SSID_W +: SSID_W]);
    endfunction

    function automatic logic [TAG_W-1:0] upd_tag(input int j);
        return upd_tag_in[j*TAG_W +: TAG_W];
    endfunction

    function automatic void model_reset();
        for (int e = 0; e < NUM_SSID; e++) begin
            m_tag[e] = '0; m_vld[e] = 0; m1_tag[e] = '0; m1_vld[e] = 0;
        end
        m1_cnt   = 0;
        m1_pulse = 0;
    endfunction

    function automatic int model_occ0();
        int n = 0;
        for (int e = 0; e < NUM_SSID; e++) n += int'(m_vld[e]);
        return n;
    endfunction

    function automatic int model_occ1();
        int n = 0;
        for (int e = 0; e < NUM_SSID; e++) n += int'(m1_vld[e]);
        return n;
    endfunction

    // Expected {valid, tag} for lookup slot k of the sweep-disabled instance.
    function automatic logic [TAG_W:0] exp_lookup(input int k);
        int             s;
        logic           v;
        logic [TAG_W-1:0] t;
        bit             found;
        s = lk_ssid(k); v = m_vld[s]; t = m_tag[s]; found = 0;
        for (int j = W - 1; j >= 0; j--) begin
            if (!found && j < k && upd_vld_in[j] && upd_ssid(j) == s) begin
                found = 1; v = 1'b1; t = upd_tag(j);
            end
        end
        if (v && lk_vld_in[k] && !flush_in && !reset_n) return {1'b1, t};
        return '0;
    endfunction

    // Apply one clock edge of the table rules to both models.
    function automatic void model_edge();
        bit fire;
        bit hit0, hit1;
        bit wrote [NUM_SSID];
        int s;
        if (reset_n) return;
        if (flush_in) begin
            for (int e = 0; e < NUM_SSID; e++) begin m_vld[e] = 0; m1_vld[e] = 0; end
            m1_cnt = 0; m1_pulse = 0;
            return;
        end
        fire     = (m1_cnt == PERIOD1 - 1);
        m1_pulse = fire;
        m1_cnt   = fire ? 0 : m1_cnt + 1;
        for (int e = 0; e < NUM_SSID; e++) begin
            hit0 = 0; hit1 = 0; wrote[e] = 0;
            for (int i = 0; i < INV_P; i++) begin
                if (inv_vld_in[i] && inv_tag_in[i*TAG_W +: TAG_W] == m_tag[e])  hit0 = 1;
                if (inv_vld_in[i] && inv_tag_in[i*TAG_W +: TAG_W] == m1_tag[e]) hit1 = 1;
            end
            if (hit0) m_vld[e] = 0;
            if (hit1 || fire) m1_vld[e] = 0;
        end
        for (int j = W - 1; j >= 0; j--) begin
            if (upd_vld_in[j]) begin
                s = upd_ssid(j);
                if (!wrote[s]) begin
                    wrote[s] = 1;
                    m_tag[s] = upd_tag(j); m_vld[s] = 1;
                    if (!fire) begin m1_tag[s] = upd_tag(j); m1_vld[s] = 1; end
                end
            end
        end
    endfunction

    task automatic idle();
        flush_in = 0; lk_ssid_in = '0; lk_vld_in = '0; upd_ssid_in = '0;
        upd_tag_in = '0; upd_vld_in = '0; inv_tag_in = '0; inv_vld_in = '0;
    endtask

    task automatic set_upd(input int j, input int ssid, input int tag);
        upd_ssid_in[j*SSID_W +: SSID_W] = SSID_W'(ssid);
        upd_tag_in[j*TAG_W +: TAG_W]    = TAG_W'(tag);
        upd_vld_in[j]                   = 1'b1;
    endtask

    task automatic set_lk(input int k, input int ssid);
        lk_ssid_in[k*SSID_W +: SSID_W] = SSID_W'(ssid);
        lk_vld_in[k]                   = 1'b1;
    endtask

    task automatic set_inv(input int i, input int tag);
        inv_tag_in[i*TAG_W +: TAG_W] = TAG_W'(tag);
        inv_vld_in[i]                = 1'b1;
    endtask

    // Advance one edge; leaves time at posedge+1.
    task automatic step();
        @(posedge clock);
        model_edge();
        #1;
    endtask

    task automatic test_reset();
        idle(); model_reset();
        set_upd(0, 5, 'h33); set_lk(1, 5); set_lk(0, 5);
        #3;
        checks++;
        if (lfs_vld0 !== '0 || lfs0 !== '0) begin
            errors++; $display("FAIL reset_lookup: vld=%b out=%h, required 0", lfs_vld0, lfs0);
        end
        checks++;
        if (occ0 !== '0 || occ1 !== '0) begin
            errors++; $display("FAIL reset_occ: occ0=%0d occ1=%0d, required 0", occ0, occ1);
        end
        checks++;
        if (clr0 !== 1'b0 || clr1 !== 1'b0) begin
            errors++; $display("FAIL reset_pulse: %b %b, required 0", clr0, clr1);
        end
        repeat (2) @(posedge clock);
        @(negedge clock);
        reset_n = 1'b0;
        idle();
        step();
        set_lk(0, 5); set_lk(3, 0);
        @(negedge clock);
        checks++;
        if (lfs_vld0 !== '0 || occ0 !== '0) begin
            errors++; $display("FAIL reset_empty: vld=%b occ=%0d, required 0", lfs_vld0, occ0);
        end
        step();
    endtask

    task automatic test_forward_basic();
        idle(); set_upd(1, 5, 'h21);
        @(negedge clock);
        step();
        idle(); set_lk(0, 5);
        @(negedge clock);
        checks++;
        if (lfs_vld0[0] !== 1'b1 || lfs0[0 +: TAG_W] !== 7'h21) begin
            errors++;
            $display("FAIL basic_lookup: vld=%b tag=%h, required 1 21", lfs_vld0[0], lfs0[0 +: TAG_W]);
        end
        checks++;
        if (occ0 !== 8'd1) begin
            errors++; $display("FAIL basic_occ: %0d, required 1", occ0);
        end
        step();
    endtask

    task automatic test_intra_bundle();
        idle();
        set_upd(0, 9, 'h10); set_upd(2, 9, 'h11);
        set_lk(0, 9); set_lk(1, 9); set_lk(2, 9); set_lk(3, 9);
        @(negedge clock);
        checks++;
        if (lfs_vld0[0] !== 1'b0 || lfs0[0 +: TAG_W] !== 7'h00) begin
            errors++; $display("FAIL fwd_slot0: vld=%b tag=%h, required 0 00", lfs_vld0[0], lfs0[0 +: TAG_W]);
        end
        checks++;
        if (lfs_vld0[1] !== 1'b1 || lfs0[TAG_W +: TAG_W] !== 7'h10) begin
            errors++; $display("FAIL fwd_slot1: vld=%b tag=%h, required 1 10", lfs_vld0[1], lfs0[TAG_W +: TAG_W]);
        end
        checks++;
        if (lfs_vld0[2] !== 1'b1 || lfs0[2*TAG_W +: TAG_W] !== 7'h10) begin
            errors++; $display("FAIL fwd_slot2: vld=%b tag=%h, required 1 10", lfs_vld0[2], lfs0[2*TAG_W +: TAG_W]);
        end
        checks++;
        if (lfs_vld0[3] !== 1'b1 || lfs0[3*TAG_W +: TAG_W] !== 7'h11) begin
            errors++; $display("FAIL fwd_slot3: vld=%b tag=%h, required 1 11", lfs_vld0[3], lfs0[3*TAG_W +: TAG_W]);
        end
        step();
        idle(); set_lk(0, 9);
        @(negedge clock);
        checks++;
        if (lfs_vld0[0] !== 1'b1 || lfs0[0 +: TAG_W] !== 7'h11) begin
            errors++; $display("FAIL upd_priority: vld=%b tag=%h, required 1 11", lfs_vld0[0], lfs0[0 +: TAG_W]);
        end
        checks++;
        if (occ0 !== 8'd2) begin
            errors++; $display("FAIL intra_occ: %0d, required 2", occ0);
        end
        step();
    endtask

    task automatic test_invalidate();
        idle(); set_upd(0, 3, 7); set_upd(1, 4, 7);
        @(negedge clock);
        step();
        idle(); set_inv(1, 7); set_lk(0, 3);
        @(negedge clock);
        checks++;
        if (occ0 !== 8'd4 || lfs_vld0[0] !== 1'b1 || lfs0[0 +: TAG_W] !== 7'h07) begin
            errors++;
            $display("FAIL inv_same_cycle: occ=%0d vld=%b tag=%h, required 4 1 07",
                     occ0, lfs_vld0[0], lfs0[0 +: TAG_W]);
        end
        step();
        idle(); set_lk(0, 3); set_lk(1, 4); set_lk(2, 5);
        @(negedge clock);
        checks++;
        if (occ0 !== 8'd2 || lfs_vld0 !== 4'b0100 || lfs0[2*TAG_W +: TAG_W] !== 7'h21) begin
            errors++;
            $display("FAIL inv_two: occ=%0d vld=%b tag2=%h, required 2 0100 21",
                     occ0, lfs_vld0, lfs0[2*TAG_W +: TAG_W]);
        end
        step();
        idle(); set_upd(0, 3, 7); set_upd(1, 4, 7);
        @(negedge clock);
        step();
        idle(); set_inv(0, 7); set_upd(2, 3, 7);
        @(negedge clock);
        step();
        idle(); set_lk(0, 3); set_lk(1, 4);
        @(negedge clock);
        checks++;
        if (occ0 !== 8'd3 || lfs_vld0 !== 4'b0001 || lfs0[0 +: TAG_W] !== 7'h07) begin
            errors++;
            $display("FAIL inv_vs_upd: occ=%0d vld=%b tag0=%h, required 3 0001 07",
                     occ0, lfs_vld0, lfs0[0 +: TAG_W]);
        end
        step();
    endtask

    task automatic test_flush();
        for (int c = 0; c < 3; c++) begin
            idle();
            for (int j = 0; j < W; j++) begin
                if (c * W + j < 10) set_upd(j, 30 + c * W + j, c * W + j + 1);
            end
            @(negedge clock);
            step();
        end
        idle(); flush_in = 1'b1; set_upd(0, 20, 'h55);
        set_lk(0, 30); set_lk(1, 31); set_lk(2, 20); set_lk(3, 5);
        @(negedge clock);
        checks++;
        if (lfs_vld0 !== '0 || lfs0 !== '0 || occ0 !== 8'd13) begin
            errors++;
            $display("FAIL flush_lookup: vld=%b out=%h occ=%0d, required 0 0 13", lfs_vld0, lfs0, occ0);
        end
        step();
        idle(); set_lk(0, 20); set_lk(1, 30);
        @(negedge clock);
        checks++;
        if (occ0 !== '0 || lfs_vld0 !== '0) begin
            errors++; $display("FAIL flush_empty: occ=%0d vld=%b, required 0 0", occ0, lfs_vld0);
        end
        step();
    endtask

    task automatic test_random();
        logic [TAG_W:0] exp;
        for (int n = 0; n < 400; n++) begin
            idle();
            for (int k = 0; k < W; k++) begin
                if ($urandom_range(3) != 0) set_lk(k, $urandom_range(15));
                if ($urandom_range(1) != 0) set_upd(k, $urandom_range(15), $urandom_range(15));
            end
            for (int i = 0; i < INV_P; i++) begin
                if ($urandom_range(3) == 0) set_inv(i, $urandom_range(15));
            end
            flush_in = ($urandom_range(31) == 0);
            @(negedge clock);
            for (int k = 0; k < W; k++) begin
                exp = exp_lookup(k);
                checks++;
                if ({lfs_vld0[k], lfs0[k*TAG_W +: TAG_W]} !== exp) begin
                    errors++;
                    $display("FAIL rand_lookup n=%0d slot=%0d: got %b/%h, required %b/%h", n, k,
                             lfs_vld0[k], lfs0[k*TAG_W +: TAG_W], exp[TAG_W], exp[TAG_W-1:0]);
                end
            end
            checks++;
            if (int'(occ0) != model_occ0() || int'(occ1) != model_occ1() || clr1 !== m1_pulse) begin
                errors++;
                $display("FAIL rand_state n=%0d: occ0=%0d occ1=%0d pulse=%b, required %0d %0d %b",
                         n, occ0, occ1, clr1, model_occ0(), model_occ1(), m1_pulse);
            end
            step();
        end
    endtask

    task automatic test_periodic();
        int pulses[$];
        bit bad;
        idle(); reset_n = 1'b1; model_reset();
        @(negedge clock);
        reset_n = 1'b0;
        for (int c = 1; c <= 57; c++) begin
            idle();
            if (c == 1) for (int j = 0; j < W; j++) set_upd(j, 40 + j, 8 + j);
            if (c == 18) begin set_upd(0, 44, 1); set_upd(1, 45, 2); end
            if (c == 24) flush_in = 1'b1;
            if (c == 26) set_upd(0, 46, 3);
            if (c > 1) @(negedge clock);
            if (clr1 === 1'b1) pulses.push_back(c - 1);
            checks++;
            if (int'(occ1) != model_occ1() || clr1 !== m1_pulse || clr0 !== 1'b0) begin
                errors++;
                $display("FAIL sweep_cycle c=%0d: occ=%0d pulse=%b pulse0=%b, required %0d %b 0",
                         c, occ1, clr1, clr0, model_occ1(), m1_pulse);
            end
            if (c == 16) begin
                checks++;
                if (occ1 !== 8'd4) begin
                    errors++; $display("FAIL sweep_before: occ=%0d, required 4", occ1);
                end
            end
            if (c == 17) begin
                checks++;
                if (occ1 !== 8'd0 || clr1 !== 1'b1) begin
                    errors++; $display("FAIL sweep_after: occ=%0d pulse=%b, required 0 1", occ1, clr1);
                end
            end
            step();
        end
        bad = (pulses.size() != 3);
        if (!bad) bad = (pulses[0] != 16 || pulses[1] != 40 || pulses[2] != 56);
        checks++;
        if (bad) begin
            errors++; $display("FAIL sweep_edges: %0d pulses seen %p, required edges 16 40 56",
                               pulses.size(), pulses);
        end
    endtask

    task automatic test_async_reset();
        logic [TAG_W:0] exp;
        idle(); set_upd(0, 50, 1); set_upd(1, 51, 2);
        @(negedge clock);
        step();
        idle(); set_lk(0, 50); set_upd(0, 60, 3); set_lk(3, 60);
        #1;
        exp = exp_lookup(0);
        checks++;
        if ({lfs_vld0[0], lfs0[0 +: TAG_W]} !== exp || exp !== {1'b1, 7'h01}) begin
            errors++; $display("FAIL pre_reset: got %b/%h, required 1/01", lfs_vld0[0], lfs0[0 +: TAG_W]);
        end
        #1;
        reset_n = 1'b1;
        model_reset();
        #1;
        checks++;
        if (lfs_vld0 !== '0 || lfs0 !== '0 || lfs_vld1 !== '0 || lfs1 !== '0) begin
            errors++; $display("FAIL async_lookup: vld=%b/%b out=%h/%h, required 0", lfs_vld0, lfs_vld1, lfs0, lfs1);
        end
        checks++;
        if (occ0 !== '0 || occ1 !== '0 || clr0 !== 1'b0 || clr1 !== 1'b0) begin
            errors++; $display("FAIL async_state: occ=%0d/%0d pulse=%b/%b, required 0", occ0, occ1, clr0, clr1);
        end
        @(negedge clock);
        reset_n = 1'b0;
        idle();
        step();
        set_lk(0, 50); set_lk(1, 51);
        @(negedge clock);
        checks++;
        if (lfs_vld0 !== '0 || occ0 !== '0) begin
            errors++; $display("FAIL after_reset: vld=%b occ=%0d, required 0 0", lfs_vld0, occ0);
        end
        step();
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not complete, required completion");
        $fatal(1);
    end

    initial begin
        test_reset();
        test_forward_basic();
        test_intra_bundle();
        test_invalidate();
        test_flush();
        test_random();
        test_periodic();
        test_async_reset();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
